fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction fetch stage directly upstream of CPU decode/execute. Holds the fetch PC and issues
// word reads to instruction memory over a req/gnt + rvalid interface. Buffers returned
// instructions with their PCs in a prefetch FIFO and presents them to decode through a
// valid/ready handshake. Taken branches/jumps redirect the PC, flush the FIFO and discard
// in-flight responses.
// PARAMETERS
// RESET_PC    32'h0000_0000  fetch address after reset
// FIFO_DEPTH  4              prefetch entries; power of 2, >=2; also the cap on outstanding + buffered
// PORTS
// clk             in   1   clock, all state on rising edge
// rst             in   1   asynchronous, active-low reset
// imem_req        out  1   read request valid
// imem_addr       out  32  word address of request (always 4-aligned)
// imem_gnt        in   1   memory accepts request this cycle
// imem_rvalid     in   1   read data valid; responses return in request order, >=1 cycle after grant
// imem_rdata      in   32  instruction word
// redirect        in   1   control-flow change from execute, single-cycle pulse
// redirect_pc     in   32  new fetch target
// inst_valid      out  1   head of FIFO valid
// inst            out  32  instruction at FIFO head
// inst_pc         out  32  PC of inst
// inst_ready      in   1   decode consumes head
// misalign_fault  out  1   sticky: redirect target not 4-aligned
// BEHAVIOUR
// - Reset (rst=0, async): state=RUN, fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0,
//   drop=0, start=0. Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0,
//   inst_pc=0, misalign_fault=0.
// - start flag sets on the first clock after rst rises; imem_req is low until then.
// - States: RUN, FAULT.
// - imem_req = start & state==RUN & !redirect & (occupancy + outstanding < FIFO_DEPTH).
//   imem_addr = fetch_pc (combinational). Grant = imem_req & imem_gnt -> fetch_pc += 4,
//   outstanding += 1. While req high and gnt low, imem_addr holds stable.
// - Response (imem_rvalid): outstanding -= 1. If drop>0: data discarded, drop -= 1.
//   Else push {resp_pc, imem_rdata}, resp_pc += 4. Grant and response in the same cycle: net
//   outstanding unchanged.
// - Credit rule guarantees the FIFO never overflows; a push to a full FIFO cannot occur.
// - inst_valid = FIFO non-empty; inst/inst_pc are the head entry (show-ahead). When empty,
//   inst/inst_pc are don't-care. Pop on inst_valid & inst_ready. Push and pop in the same cycle
//   are allowed at any occupancy, including full; occupancy is unchanged.
// - Latency: grant at cycle N, rvalid at N+1 -> inst_valid at N+2 (one FIFO register stage).
// - Redirect has priority over grant, response push and pop in its cycle:
//   FIFO cleared, no pop is counted, drop = outstanding - (rvalid this cycle ? 1 : 0),
//   fetch_pc = resp_pc = redirect_pc, and no request is issued that cycle.
//   - If redirect_pc[1:0]==0: state=RUN, misalign_fault=0.
//   - Else: state=FAULT, misalign_fault=1.
// - FAULT: no requests are issued. In-flight responses are still drained via drop.
//   inst_valid stays 0. Only an aligned redirect or reset leaves FAULT.
// - Pointer and counter wrap: FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
//   fetch_pc wraps 32'hFFFF_FFFC -> 0.
// - Reset asserted mid-operation discards all buffered and in-flight state immediately.
//   Responses arriving while rst=0 are ignored.
// TESTING
// 1 Reset release; gnt=1, rvalid one cycle after each grant, inst_ready=1 -> inst_pc
//   0x0,0x4,0x8,... back to back. First inst_valid 3 cycles after rst rises.
// 2 inst_ready=0 with memory always granting -> exactly 4 grants (0x0..0xC), then imem_req=0.
//   inst_pc=0x0 stays held. Raise ready -> one pop per cycle and requests resume at 0x10.
// 3 Two grants outstanding, redirect to 0x100 -> next two rvalid responses discarded.
//   Next inst_pc=0x100, imem_addr=0x100 the cycle after redirect.
// 4 Redirect to 0x102 -> misalign_fault=1, imem_req=0, inst_valid=0 indefinitely.
//   Redirect to 0x200 -> fault clears, fetch resumes at 0x200.
// 5 imem_gnt held low 5 cycles with req high -> imem_addr constant, no FIFO change.
//   Redirect plus simultaneous rvalid -> that response is dropped.
// 6 rst pulsed low with FIFO full and 2 outstanding -> inst_valid=0 and imem_req=0 at once.
//   After release, fetch restarts at RESET_PC. Stale responses received during reset never
//   appear on the output.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit (master) and its surroundings (slave): the
// instruction-memory req/gnt + rvalid port and the valid/ready port to decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads, buffers returned words with their PCs in a
// show-ahead prefetch FIFO, and flushes/redirects on control-flow changes from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        bus,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                misalign_fault
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    fetch_state_e     state;
    logic             started;
    logic [31:0]      fetchPc;
    logic [31:0]      respPc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] dropCnt;
    logic [CNT_W-1:0] occupancy;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;

    logic [31:0] memInst [FIFO_DEPTH];
    logic [31:0] memPc   [FIFO_DEPTH];

    logic             reqValid;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit;
    logic [CNT_W-1:0] outNext;
    logic [CNT_W-1:0] occNext;

    // Credit counts both buffered entries and requests still in flight, so every
    // granted response is guaranteed a FIFO slot when it returns.
    assign credit   = {1'b0, occupancy} + {1'b0, outstanding};
    assign reqValid = started && (state == RUN) && !redirect && (credit < DEPTH_LIM);
    assign grant    = reqValid && bus.imem_gnt;
    assign rsp      = bus.imem_rvalid;
    assign push     = rsp && (dropCnt == '0) && !redirect;
    assign pop      = bus.inst_valid && bus.inst_ready && !redirect;

    assign bus.imem_req   = reqValid;
    assign bus.imem_addr  = fetchPc;
    assign bus.inst_valid = (occupancy != '0);
    assign bus.inst       = bus.inst_valid ? memInst[rdPtr] : '0;
    assign bus.inst_pc    = bus.inst_valid ? memPc[rdPtr]   : '0;

    // NOTE: every variable written in an always_comb gets a default on the first line,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        outNext = outstanding;
        if (grant && !rsp) begin
            outNext = outstanding + CNT_W'(1);
        end else if (!grant && rsp) begin
            outNext = outstanding - CNT_W'(1);
        end
    end

    always_comb begin
        occNext = occupancy;
        if (push && !pop) begin
            occNext = occupancy + CNT_W'(1);
        end else if (!push && pop) begin
            occNext = occupancy - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            started        <= 1'b0;
            fetchPc        <= RESET_PC;
            respPc         <= RESET_PC;
            outstanding    <= '0;
            dropCnt        <= '0;
            occupancy      <= '0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            misalign_fault <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect) begin
                // No grant is possible this cycle, so outNext is exactly what is
                // still in flight after this cycle's response; all of it is stale.
                occupancy   <= '0;
                wrPtr       <= '0;
                rdPtr       <= '0;
                outstanding <= outNext;
                dropCnt     <= outNext;
                fetchPc     <= redirect_pc;
                respPc      <= redirect_pc;
                if (redirect_pc[1:0] == 2'b00) begin
                    state          <= RUN;
                    misalign_fault <= 1'b0;
                end else begin
                    state          <= FAULT;
                    misalign_fault <= 1'b1;
                end
            end else begin
                outstanding <= outNext;
                occupancy   <= occNext;
                if (grant) begin
                    fetchPc <= fetchPc + 32'd4;
                end
                if (rsp) begin
                    if (dropCnt != '0) begin
                        dropCnt <= dropCnt - CNT_W'(1);
                    end else begin
                        respPc <= respPc + 32'd4;
                    end
                end
                if (push) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: the FIFO storage has no reset; its contents are only observable through
    // inst_valid, which is reset, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            memInst[wrPtr] <= bus.imem_rdata;
            memPc[wrPtr]   <= respPc;
        end
    end

    a_req_aligned: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_req |-> (bus.imem_addr[1:0] == 2'b00));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> ((occupancy < DEPTH_LIM[CNT_W-1:0]) || pop));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        rsp |-> (outstanding != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the driver predicts the decode-visible
// instruction stream from control-flow events, a negedge monitor compares it.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        misalignFault;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .redirect      (redirect),
        .redirect_pc   (redirectPc),
        .misalign_fault(misalignFault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          stale;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    pend_t       pendQ[$];
    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          grantCount = 0;
    logic [31:0] expPc = RESET_PC;
    logic [31:0] reqPc = RESET_PC;
    bit          faultNow = 1'b0;
    bit          faultNext = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory side and scoreboard: grants are recorded for the memory model, decode
    // handshakes are compared against the predicted stream.
    always @(negedge clk) begin
        if (rst) begin
            check("misalign_fault", {31'b0, misalignFault}, {31'b0, faultNow});
            if (faultNow) begin
                check("fault_req", {31'b0, bus.imem_req}, 32'd0);
                check("fault_valid", {31'b0, bus.inst_valid}, 32'd0);
            end
            if (redirect) begin
                check("redirect_req", {31'b0, bus.imem_req}, 32'd0);
            end
            if (bus.imem_req && bus.imem_gnt) begin
                check("req_addr", bus.imem_addr, reqPc);
                pendQ.push_back('{bus.imem_addr, cyc, 1'b0});
                reqPc += 32'd4;
                grantCount++;
            end
            if (bus.inst_valid && bus.inst_ready && !redirect) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, expected no instruction (cycle %0d)",
                             bus.inst_pc, bus.inst, cyc);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("inst_pc", bus.inst_pc, e.pc);
                    check("inst", bus.inst, e.data);
                end
            end
        end
    end

    // One clock of stimulus: memory response, grant, decode ready and redirect.
    task automatic cycle(input bit g, input bit rvEn, input bit rdy, input bit redir,
                         input logic [31:0] tgt);
        pend_t e;
        bit    rsp;
        @(posedge clk);
        #1;
        cyc++;
        faultNow = faultNext;
        rsp = rvEn && (pendQ.size() > 0);
        if (rsp) rsp = (pendQ[0].cyc < cyc);
        if (redir) begin
            foreach (pendQ[i]) pendQ[i].stale = 1'b1;
        end
        bus.imem_rvalid = rsp;
        bus.imem_rdata  = $urandom;
        if (rsp) begin
            e = pendQ.pop_front();
            bus.imem_rdata = mem_word(e.addr);
            if (!e.stale) begin
                expQ.push_back('{expPc, mem_word(expPc)});
                expPc += 32'd4;
            end
        end
        if (redir) begin
            expQ.delete();
            expPc     = tgt;
            reqPc     = tgt;
            faultNext = (tgt[1:0] != 2'b00);
        end
        bus.imem_gnt   = g;
        bus.inst_ready = rdy;
        redirect       = redir;
        redirectPc     = tgt;
    endtask

    task automatic do_reset(input int hold, input bit staleRsp);
        @(posedge clk);
        #1;
        cyc++;
        rst             = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.inst_ready  = 1'b0;
        redirect        = 1'b0;
        pendQ.delete();
        expQ.delete();
        expPc     = RESET_PC;
        reqPc     = RESET_PC;
        faultNow  = 1'b0;
        faultNext = 1'b0;
        #1;
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_fault", {31'b0, misalignFault}, 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.imem_rvalid = staleRsp;
            bus.imem_rdata  = 32'hDEAD_0000 | i;
        end
        @(posedge clk);
        #1;
        cyc++;
        rst             = 1'b1;
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        check("start_req", {31'b0, bus.imem_req}, 32'd0);
    endtask

    initial begin
        int          g0;
        logic [31:0] a0;
        logic [31:0] pc0;
        bit          redir;
        logic [31:0] tgt;
        int          r;

        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;

        // Reset release, first-instruction latency, then back-to-back stream.
        do_reset(2, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 1, 1, 0, '0);
            @(negedge clk);
            check("first_valid_latency", {31'b0, bus.inst_valid}, {31'b0, k == 3});
        end
        for (int k = 0; k < 16; k++) begin
            cycle(1, 1, 1, 0, '0);
            @(negedge clk);
            check("b2b_valid", {31'b0, bus.inst_valid}, 32'd1);
        end

        // Decode stalled: credit limits grants to DEPTH, head is held.
        do_reset(1, 1'b0);
        g0 = grantCount;
        repeat (12) cycle(1, 1, 0, 0, '0);
        @(negedge clk);
        check("credit_grants", grantCount - g0, DEPTH);
        check("credit_req_low", {31'b0, bus.imem_req}, 32'd0);
        check("held_pc", bus.inst_pc, RESET_PC);
        repeat (12) cycle(1, 1, 1, 0, '0);

        // Redirect with two requests in flight.
        do_reset(1, 1'b0);
        cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 1, 1, 32'h0000_0100);
        cycle(0, 1, 1, 0, '0);
        @(negedge clk);
        check("redirect_addr", bus.imem_addr, 32'h0000_0100);
        repeat (12) cycle(1, 1, 1, 0, '0);

        // Misaligned redirect faults; an aligned one recovers.
        cycle(1, 1, 1, 1, 32'h0000_0102);
        repeat (8) cycle(1, 1, 1, 0, '0);
        @(negedge clk);
        check("fault_sticky", {31'b0, misalignFault}, 32'd1);
        cycle(1, 1, 1, 1, 32'h0000_0200);
        repeat (12) cycle(1, 1, 1, 0, '0);

        // Grant withheld: address and FIFO head hold steady.
        repeat (2) cycle(0, 1, 0, 0, '0);
        @(negedge clk);
        a0  = bus.imem_addr;
        pc0 = bus.inst_pc;
        check("gnt_low_addr0", a0, reqPc);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 0, '0);
            @(negedge clk);
            check("gnt_low_req", {31'b0, bus.imem_req}, 32'd1);
            check("gnt_low_addr", bus.imem_addr, a0);
            check("gnt_low_head", bus.inst_pc, pc0);
        end
        // Redirect coinciding with a response: that response is dropped.
        cycle(1, 0, 0, 0, '0);
        cycle(0, 1, 1, 1, 32'h0000_0300);
        repeat (12) cycle(1, 1, 1, 0, '0);

        // Reset with buffered and in-flight work; stale responses during reset.
        do_reset(1, 1'b0);
        cycle(1, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, '0);
        cycle(1, 1, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);
        @(negedge clk);
        check("pre_reset_valid", {31'b0, bus.inst_valid}, 32'd1);
        do_reset(3, 1'b1);
        repeat (15) cycle(1, 1, 1, 0, '0);

        // Randomized traffic, including wrap of the fetch address.
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                redir = ($urandom_range(0, 99) < 4);
                tgt   = $urandom & ~32'h3;
                if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 4) == 0) tgt = 32'hFFFF_FFF0;
                cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                      $urandom_range(0, 99) < 70, redir, tgt);
            end
        end
        repeat (10) cycle(0, 1, 1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
